// File: rtl/axi_cmd_seq_if.sv
// AXI4 bus bundle used by axi_cmd_seq: single-beat subset with address, data and response channels.
`timescale 1ns/1ps
interface axi4 #(
  parameter int ALEN  = 32,
  parameter int XLEN  = 32,
  parameter int IDLEN = 5
);
  logic              awValid;
  logic              awReady;
  logic [ALEN-1:0]   awAddr;
  logic [IDLEN-1:0]  awId;
  logic [7:0]        awLen;
  logic [2:0]        awSize;
  logic [1:0]        awBurst;
  logic              wValid;
  logic              wReady;
  logic [XLEN-1:0]   wData;
  logic [XLEN/8-1:0] wStrb;
  logic              wLast;
  logic              bValid;
  logic              bReady;
  logic [1:0]        bResp;
  logic              arValid;
  logic              arReady;
  logic [ALEN-1:0]   arAddr;
  logic [IDLEN-1:0]  arId;
  logic [7:0]        arLen;
  logic [2:0]        arSize;
  logic [1:0]        arBurst;
  logic              rValid;
  logic              rReady;
  logic [XLEN-1:0]   rData;
  logic [1:0]        rResp;

  modport master (
    output awValid, awAddr, awId, awLen, awSize, awBurst,
    input  awReady,
    output wValid, wData, wStrb, wLast,
    input  wReady,
    input  bValid, bResp,
    output bReady,
    output arValid, arAddr, arId, arLen, arSize, arBurst,
    input  arReady,
    input  rValid, rData, rResp,
    output rReady
  );

  modport slave (
    input  awValid, awAddr, awId, awLen, awSize, awBurst,
    output awReady,
    input  wValid, wData, wStrb, wLast,
    output wReady,
    output bValid, bResp,
    input  bReady,
    input  arValid, arAddr, arId, arLen, arSize, arBurst,
    output arReady,
    output rValid, rData, rResp,
    input  rReady
  );
endinterface

// File: rtl/axi_cmd_seq.sv
// AXI4 master command sequencer: buffers write/read/poll commands in a FIFO and runs them in order.
// Optional bus watchdog enabled by defining AXI_CMD_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module axi_cmd_seq #(
  parameter int DEPTH    = 8,
  parameter int ALEN     = 32,
  parameter int XLEN     = 32,
  parameter int IDLEN    = 5,
  parameter int POLL_MAX = 1024,
  parameter int POLL_GAP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [ALEN-1:0] cmd_addr,
  input  logic [XLEN-1:0] cmd_data,
  input  logic [XLEN-1:0] cmd_mask,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy,
  output logic            err,
  output logic [1:0]      err_code,
  input  logic            clear,
  axi4.master             bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(POLL_MAX + 1);
  localparam int GW = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {IDLE, WADDR, BRESP, RADDR, RRESP, PGAP, HALT} state_t;

  typedef struct packed {
    logic [1:0]      op;
    logic [ALEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] mask;
  } cmd_t;

  cmd_t          fifoMem [DEPTH];
  cmd_t          head;
  state_t        state_q, state_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic          cmdReady_q, cmdReady_d;
  logic          awDone_q, awDone_d, wDone_q, wDone_d;
  logic [CW-1:0] pollCnt_q, pollCnt_d;
  logic [GW-1:0] gapCnt_q, gapCnt_d;
  logic [1:0]    errCode_q, errCode_d;
  logic          rspValid_q, rspValid_d;
  logic [XLEN-1:0] rspData_q, rspData_d;
  logic          push, pop, flush, empty, timeout;

  assign head  = fifoMem[rdPtr_q[AW-1:0]];
  assign empty = (wrPtr_q == rdPtr_q);
  assign push  = cmd_valid && cmdReady_q;
  assign flush = (state_q == HALT) && clear;

  assign bus.awAddr  = head.addr;
  assign bus.awId    = '0;
  assign bus.awLen   = '0;
  assign bus.awSize  = 3'($clog2(XLEN/8));
  assign bus.awBurst = 2'b01;
  assign bus.wData   = head.data;
  assign bus.wStrb   = '1;
  assign bus.wLast   = 1'b1;
  assign bus.arAddr  = head.addr;
  assign bus.arId    = '0;
  assign bus.arLen   = '0;
  assign bus.arSize  = 3'($clog2(XLEN/8));
  assign bus.arBurst = 2'b01;

  assign cmd_ready = cmdReady_q;
  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;
  assign busy      = !empty || (state_q != IDLE);
  assign err       = (state_q == HALT);
  assign err_code  = errCode_q;

`ifdef AXI_CMD_SEQ_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
  logic        busState;

  assign busState = (state_q == WADDR) || (state_q == BRESP) ||
                    (state_q == RADDR) || (state_q == RRESP);
  assign timeout  = busState && (wdog_q == 16'hFFFF);

  // Restart the count on every state change so each phase gets the full window.
  always_comb begin
    wdog_d = '0;
    if (busState && (state_d == state_q)) wdog_d = wdog_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // FIFO storage carries no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr_q[AW-1:0]] <= '{cmd_op, cmd_addr, cmd_data, cmd_mask};
  end

  always_comb begin
    wrPtr_d    = wrPtr_q + PW'(push);
    rdPtr_d    = rdPtr_q + PW'(pop);
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end
    cmdReady_d = ((wrPtr_d - rdPtr_d) != PW'(DEPTH));
  end

  always_comb begin
    state_d     = state_q;
    awDone_d    = awDone_q;
    wDone_d     = wDone_q;
    pollCnt_d   = pollCnt_q;
    gapCnt_d    = gapCnt_q;
    errCode_d   = errCode_q;
    rspValid_d  = 1'b0;
    rspData_d   = rspData_q;
    pop         = 1'b0;
    bus.awValid = 1'b0;
    bus.wValid  = 1'b0;
    bus.bReady  = 1'b0;
    bus.arValid = 1'b0;
    bus.rReady  = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        case (head.op)
          2'b00: begin
            state_d  = WADDR;
            awDone_d = 1'b0;
            wDone_d  = 1'b0;
          end
          2'b01, 2'b10: begin
            state_d   = RADDR;
            pollCnt_d = '0;
          end
          default: begin
            state_d   = HALT;
            errCode_d = 2'b11;
          end
        endcase
      end
      WADDR: begin
        bus.awValid = !awDone_q;
        bus.wValid  = !wDone_q;
        awDone_d    = awDone_q || bus.awReady;
        wDone_d     = wDone_q || bus.wReady;
        if (awDone_d && wDone_d) state_d = BRESP;
      end
      BRESP: begin
        bus.bReady = 1'b1;
        if (bus.bValid) begin
          if (bus.bResp == 2'b00) begin
            pop     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d   = HALT;
            errCode_d = 2'b01;
          end
        end
      end
      RADDR: begin
        bus.arValid = 1'b1;
        if (bus.arReady) state_d = RRESP;
      end
      RRESP: begin
        bus.rReady = 1'b1;
        if (bus.rValid) begin
          if (bus.rResp != 2'b00) begin
            state_d   = HALT;
            errCode_d = 2'b01;
          end else if ((head.op == 2'b01) || (((bus.rData ^ head.data) & head.mask) == '0)) begin
            rspValid_d = 1'b1;
            rspData_d  = bus.rData;
            pop        = 1'b1;
            state_d    = IDLE;
          end else if (pollCnt_q == CW'(POLL_MAX - 1)) begin
            state_d   = HALT;
            errCode_d = 2'b10;
          end else begin
            pollCnt_d = pollCnt_q + CW'(1);
            gapCnt_d  = '0;
            state_d   = PGAP;
          end
        end
      end
      PGAP: begin
        if (gapCnt_q == GW'(POLL_GAP - 1)) state_d = RADDR;
        else                               gapCnt_d = gapCnt_q + GW'(1);
      end
      HALT: if (clear) begin
        state_d   = IDLE;
        errCode_d = 2'b00;
      end
      default: state_d = IDLE;
    endcase
    // A watchdog expiry withdraws every handshake signal so nothing completes half-way.
    if (timeout) begin
      state_d     = HALT;
      errCode_d   = 2'b11;
      pop         = 1'b0;
      rspValid_d  = 1'b0;
      rspData_d   = rspData_q;
      bus.awValid = 1'b0;
      bus.wValid  = 1'b0;
      bus.bReady  = 1'b0;
      bus.arValid = 1'b0;
      bus.rReady  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      cmdReady_q <= 1'b1;
      awDone_q   <= 1'b0;
      wDone_q    <= 1'b0;
      pollCnt_q  <= '0;
      gapCnt_q   <= '0;
      errCode_q  <= 2'b00;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      cmdReady_q <= cmdReady_d;
      awDone_q   <= awDone_d;
      wDone_q    <= wDone_d;
      pollCnt_q  <= pollCnt_d;
      gapCnt_q   <= gapCnt_d;
      errCode_q  <= errCode_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
    end
  end
endmodule

// File: tb/tb_axi_cmd_seq.sv
// Scoreboard bench for axi_cmd_seq with a scriptable AXI slave; exercises the watchdog when AXI_CMD_SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_axi_cmd_seq;
  localparam int DEPTH    = 8;
  localparam int ALEN     = 32;
  localparam int XLEN     = 32;
  localparam int IDLEN    = 5;
  localparam int POLL_MAX = 4;
  localparam int POLL_GAP = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid, cmd_ready, rsp_valid, busy, err, clear;
  logic [1:0]      cmd_op, err_code;
  logic [ALEN-1:0] cmd_addr;
  logic [XLEN-1:0] cmd_data, cmd_mask, rsp_data;

  axi4 #(.ALEN(ALEN), .XLEN(XLEN), .IDLEN(IDLEN)) bus ();

  axi_cmd_seq #(.DEPTH(DEPTH), .ALEN(ALEN), .XLEN(XLEN), .IDLEN(IDLEN),
                .POLL_MAX(POLL_MAX), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .err(err),
    .err_code(err_code), .clear(clear), .bus(bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int cycle   = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int          awDelay = 0, wDelay = 0;
  logic        awStall = 1'b0, bStall = 1'b0, arStall = 1'b0;
  logic [1:0]  bRespCfg = 2'b00;
  logic [31:0] rDataQ[$];
  logic [31:0] expQ[$];
  int          arTimes[$];
  int          awCount = 0, wCount = 0, bCount = 0, arCount = 0, rspCount = 0;
  logic [31:0] lastAwAddr = '0, lastWData = '0;
  logic [3:0]  lastStrb = '0;
  logic [2:0]  lastAwSize = '0;
  logic        lastWLast = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] mask);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_mask  = mask;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (n == 200) checkOutput("push accepted", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input int maxCyc, input string name);
    int n = 0;
    while (busy && n < maxCyc) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(busy), 0);
  endtask

  task automatic waitErr(input int maxCyc, input string name);
    int n = 0;
    while (!err && n < maxCyc) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(err), 1);
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Slave channels react on the falling edge so the DUT samples stable values.
  initial begin
    int waitCnt = 0;
    bus.awReady = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.awReady) bus.awReady = 1'b0;
      else if (bus.awValid && !awStall) begin
        if (waitCnt < awDelay) waitCnt++;
        else begin
          bus.awReady = 1'b1;
          waitCnt = 0;
        end
      end
      if (bus.awValid && bus.awReady) begin
        awCount++;
        lastAwAddr = bus.awAddr;
        lastAwSize = bus.awSize;
      end
    end
  end

  initial begin
    int waitCnt = 0;
    bus.wReady = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.wReady) bus.wReady = 1'b0;
      else if (bus.wValid) begin
        if (waitCnt < wDelay) waitCnt++;
        else begin
          bus.wReady = 1'b1;
          waitCnt = 0;
        end
      end
      if (bus.wValid && bus.wReady) begin
        wCount++;
        lastWData = bus.wData;
        lastStrb  = bus.wStrb;
        lastWLast = bus.wLast;
      end
    end
  end

  initial begin
    bus.bValid = 1'b0;
    bus.bResp  = 2'b00;
    forever begin
      @(negedge clk);
      if (bus.bValid) bus.bValid = 1'b0;
      else if (bus.bReady && !bStall) begin
        bus.bValid = 1'b1;
        bus.bResp  = bRespCfg;
        bCount++;
      end
    end
  end

  initial begin
    bus.arReady = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.arReady) bus.arReady = 1'b0;
      else if (bus.arValid && !arStall) bus.arReady = 1'b1;
      if (bus.arValid && bus.arReady) begin
        arCount++;
        arTimes.push_back(cycle);
      end
    end
  end

  initial begin
    bus.rValid = 1'b0;
    bus.rData  = '0;
    bus.rResp  = 2'b00;
    forever begin
      @(negedge clk);
      if (bus.rValid) bus.rValid = 1'b0;
      else if (bus.rReady && rDataQ.size() > 0) begin
        bus.rValid = 1'b1;
        bus.rData  = rDataQ.pop_front();
        bus.rResp  = 2'b00;
      end
    end
  end

  // Monitor: every response pulse is matched against the oldest expected value.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        rspCount++;
        checkOutput("rsp expected", 32'(expQ.size() > 0), 1);
        if (expQ.size() > 0) checkOutput("rsp_data", rsp_data, expQ.pop_front());
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL global time limit: got running, expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int prevAw, prevW, prevB, prevAr, prevRsp, n;
    logic sawEarly;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_mask  = '0;
    clear     = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset cmd_ready", 32'(cmd_ready), 1);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 0);
    checkOutput("reset rsp_data", rsp_data, 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset err", 32'(err), 0);
    checkOutput("reset err_code", 32'(err_code), 0);
    checkOutput("reset bus handshakes",
                32'({bus.awValid, bus.wValid, bus.arValid, bus.bReady, bus.rReady}), 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] write with AW accepted before W");
    awDelay = 0;
    wDelay  = 2;
    applyStimulus(2'b00, 32'h0001_0000, 32'h0000_0A2C, 32'h0);
    waitIdle(50, "write idle");
    checkOutput("write aw count", awCount, 1);
    checkOutput("write w count", wCount, 1);
    checkOutput("write b count", bCount, 1);
    checkOutput("write aw addr", lastAwAddr, 32'h0001_0000);
    checkOutput("write w data", lastWData, 32'h0000_0A2C);
    checkOutput("write strb", 32'(lastStrb), 32'hF);
    checkOutput("write wlast", 32'(lastWLast), 1);
    checkOutput("write size", 32'(lastAwSize), 2);
    checkOutput("write err", 32'(err), 0);
    wDelay = 0;

    $display("[TB] single read");
    prevAr = arCount;
    prevRsp = rspCount;
    rDataQ.push_back(32'h5A);
    expQ.push_back(32'h5A);
    applyStimulus(2'b01, 32'h0001_0014, 32'h0, 32'h0);
    waitIdle(50, "read idle");
    tick();
    checkOutput("read ar count", arCount - prevAr, 1);
    checkOutput("read rsp pulses", rspCount - prevRsp, 1);
    checkOutput("read err", 32'(err), 0);

    $display("[TB] poll succeeding on third read");
    prevAr = arCount;
    prevRsp = rspCount;
    arTimes.delete();
    rDataQ.push_back(32'h1);
    rDataQ.push_back(32'h1);
    rDataQ.push_back(32'h0);
    expQ.push_back(32'h0);
    applyStimulus(2'b10, 32'h0001_0014, 32'h0, 32'h1);
    waitIdle(200, "poll idle");
    tick();
    checkOutput("poll ar count", arCount - prevAr, 3);
    checkOutput("poll rsp pulses", rspCount - prevRsp, 1);
    if (arTimes.size() == 3) begin
      checkOutput("poll gap 1", 32'((arTimes[1] - arTimes[0]) >= POLL_GAP), 1);
      checkOutput("poll gap 2", 32'((arTimes[2] - arTimes[1]) >= POLL_GAP), 1);
    end else checkOutput("poll ar times", arTimes.size(), 3);

    $display("[TB] poll exhausting its read budget");
    prevAr = arCount;
    prevRsp = rspCount;
    repeat (POLL_MAX) rDataQ.push_back(32'h1);
    applyStimulus(2'b10, 32'h0001_0014, 32'h0, 32'h1);
    waitErr(300, "poll exhaust err");
    checkOutput("poll exhaust ar count", arCount - prevAr, POLL_MAX);
    checkOutput("poll exhaust err_code", 32'(err_code), 32'h2);
    checkOutput("poll exhaust no rsp", rspCount - prevRsp, 0);
    checkOutput("poll exhaust busy", 32'(busy), 1);
    pulseClear();
    checkOutput("clear err", 32'(err), 0);
    checkOutput("clear err_code", 32'(err_code), 0);
    checkOutput("clear busy", 32'(busy), 0);
    rDataQ.delete();

    $display("[TB] fill FIFO behind a stalled write response");
    bStall = 1'b1;
    prevAw = awCount;
    prevB  = bCount;
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(2'b00, 32'h0002_0000 + 32'(4 * i), 32'(i), 32'h0);
    checkOutput("full cmd_ready", 32'(cmd_ready), 0);
    bStall   = 1'b0;
    sawEarly = 1'b0;
    n = 0;
    while (bCount == prevB && n < 50) begin
      if (cmd_ready) sawEarly = 1'b1;
      tick();
      n++;
    end
    checkOutput("full ready before pop", 32'(sawEarly), 0);
    checkOutput("full first b seen", 32'(bCount != prevB), 1);
    checkOutput("full ready after pop", 32'(cmd_ready), 1);
    waitIdle(400, "fill drain idle");
    checkOutput("fill aw count", awCount - prevAw, DEPTH);
    checkOutput("fill b count", bCount - prevB, DEPTH);

    $display("[TB] write answered with SLVERR");
    prevAw = awCount;
    prevW  = wCount;
    bRespCfg = 2'b10;
    applyStimulus(2'b00, 32'h0001_0008, 32'h55, 32'h0);
    waitErr(50, "slverr err");
    checkOutput("slverr err_code", 32'(err_code), 32'h1);
    bRespCfg = 2'b00;
    applyStimulus(2'b00, 32'h0001_000C, 32'h66, 32'h0);
    repeat (20) tick();
    checkOutput("slverr halted aw", awCount - prevAw, 1);
    checkOutput("slverr halted w", wCount - prevW, 1);
    pulseClear();
    checkOutput("slverr cleared err", 32'(err), 0);
    checkOutput("slverr flushed busy", 32'(busy), 0);
    repeat (10) tick();
    checkOutput("slverr no aw after clear", awCount - prevAw, 1);

    $display("[TB] reserved opcode");
    prevAw = awCount;
    prevAr = arCount;
    applyStimulus(2'b11, 32'h0001_0000, 32'h0, 32'h0);
    waitErr(20, "reserved err");
    checkOutput("reserved err_code", 32'(err_code), 32'h3);
    checkOutput("reserved no bus", (awCount - prevAw) + (arCount - prevAr), 0);
    pulseClear();
    checkOutput("reserved cleared", 32'(busy), 0);

    $display("[TB] reset during a write");
    awStall = 1'b1;
    applyStimulus(2'b00, 32'h0001_0010, 32'h77, 32'h0);
    repeat (3) tick();
    checkOutput("midreset aw pending", 32'(bus.awValid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset valids", 32'({bus.awValid, bus.wValid, bus.arValid}), 0);
    checkOutput("midreset busy", 32'(busy), 0);
    checkOutput("midreset cmd_ready", 32'(cmd_ready), 1);
    tick();
    rst_n   = 1'b1;
    awStall = 1'b0;
    tick();

`ifdef AXI_CMD_SEQ_TIMEOUT_EN
    $display("[TB] read address never accepted");
    prevAr  = arCount;
    arStall = 1'b1;
    applyStimulus(2'b01, 32'h0001_0020, 32'h0, 32'h0);
    waitErr(70000, "timeout err");
    checkOutput("timeout err_code", 32'(err_code), 32'h3);
    checkOutput("timeout no ar", arCount - prevAr, 0);
    tick();
    checkOutput("timeout arvalid dropped", 32'(bus.arValid), 0);
    arStall = 1'b0;
    pulseClear();
    checkOutput("timeout cleared", 32'(err), 0);
`endif

    checkOutput("rsp queue drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
